// File: rtl/gate_vector_sweeper_pkg.sv
// Shared definitions for the gate vector sweeper: the sweep states, the
// field widths, and the reference model of the three-input gate block.
package sweep_pkg;

  localparam int ERR_W = 4;
  localparam int VEC_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_e;

  // Expected {d,e} for vector {a,b,c}: d = (a & b) | ~c, e = ~c.
  function automatic logic [1:0] gate_expect(input logic [VEC_W-1:0] vec);
    logic a, b, c;
    a = vec[2];
    b = vec[1];
    c = vec[0];
    return {(a & b) | ~c, ~c};
  endfunction

endpackage

// File: rtl/gate_vector_sweeper_if.sv
// Bundle between the sweeper, its test controller and the gate block.
// The slave modport is the sweeper; the master modport is whoever drives
// start and returns the gate responses. The signature output only exists
// when SWEEP_SIGNATURE_EN is defined.
interface gate_vector_sweeper_if;
  import sweep_pkg::*;

  logic             start;
  logic             busy;
  logic             done;
  logic             fail;
  logic [ERR_W-1:0] err_cnt;
  logic [VEC_W-1:0] last_fail_vec;
  logic             a_o;
  logic             b_o;
  logic             c_o;
  logic             d_i;
  logic             e_i;
`ifdef SWEEP_SIGNATURE_EN
  logic [15:0]      sig_o;

  modport master (
    output start, d_i, e_i,
    input  busy, done, fail, err_cnt, last_fail_vec, a_o, b_o, c_o, sig_o
  );

  modport slave (
    input  start, d_i, e_i,
    output busy, done, fail, err_cnt, last_fail_vec, a_o, b_o, c_o, sig_o
  );
`else
  modport master (
    output start, d_i, e_i,
    input  busy, done, fail, err_cnt, last_fail_vec, a_o, b_o, c_o
  );

  modport slave (
    input  start, d_i, e_i,
    output busy, done, fail, err_cnt, last_fail_vec, a_o, b_o, c_o
  );
`endif

endinterface

// File: rtl/gate_vector_sweeper_hold_timer.sv
// Hold timer: counts the cycles a vector has been driven and flags the
// cycle whose closing edge is the sample edge (count == HOLD_CYCLES-1).
// The count restarts on clr and after every tick.
module sweep_hold_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CNT_W-1:0] hold_cnt;

  assign tick = en && (hold_cnt == CNT_W'(HOLD_CYCLES - 1));

  // Advance the hold count while enabled; wrap to zero at the sample edge.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hold_cnt <= '0;
    end else if (tick) begin
      hold_cnt <= '0;
    end else if (en) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gate_vector_sweeper.sv
// Gate vector sweeper: steps {a,b,c} through 0..NUM_VEC-1, holding each
// vector HOLD_CYCLES cycles, and checks {d,e} against the reference at
// the last edge of each hold. Define SWEEP_SIGNATURE_EN to add a 16-bit
// shift signature of the sampled responses.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | waiting for start, gate inputs held at 0
//   ST_DRIVE | driving vec, sampling at each hold timer tick
//   ST_DONE  | one-cycle done pulse, then back to idle
module gate_vector_sweeper
  import sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int NUM_VEC     = 8
) (
  input logic                 clk,
  input logic                 rst,
  gate_vector_sweeper_if.slave bus
);

  sweep_state_e     state;
  logic [VEC_W-1:0] vec;
  logic [ERR_W-1:0] err_cnt;
  logic [VEC_W-1:0] last_fail_vec;
  logic             fail;
  logic             tick;
  logic             accept;
  logic             driving;
  logic             last_vec;
  logic             mismatch;

  assign driving  = (state == ST_DRIVE);
  assign accept   = (state == ST_IDLE) && bus.start;
  assign last_vec = (vec == VEC_W'(NUM_VEC - 1));
  assign mismatch = ({bus.d_i, bus.e_i} != gate_expect(vec));

  sweep_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (driving),
    .tick(tick)
  );

  // Sweep sequencing: idle -> drive on start, drive -> done after the last sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (bus.start) state <= ST_DRIVE;
        ST_DRIVE: if (tick && last_vec) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Vector stepping and response checking; vec returns to 0 on leaving DRIVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec           <= '0;
      err_cnt       <= '0;
      last_fail_vec <= '0;
      fail          <= 1'b0;
    end else begin
      fail <= 1'b0;
      if (accept) begin
        vec           <= '0;
        err_cnt       <= '0;
        last_fail_vec <= '0;
      end else if (tick) begin
        if (mismatch) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          last_fail_vec <= vec;
          fail          <= 1'b1;
        end
        vec <= last_vec ? '0 : vec + 1'b1;
      end
    end
  end

`ifdef SWEEP_SIGNATURE_EN
  logic [15:0] sig;

  // Shift each sampled {d,e} pair into the signature.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      sig <= '0;
    end else if (tick) begin
      sig <= {sig[13:0], bus.d_i, bus.e_i};
    end
  end

  assign bus.sig_o = sig;
`endif

  // Gate inputs follow vec only while driving so idle/done always present 000.
  assign bus.a_o           = driving & vec[2];
  assign bus.b_o           = driving & vec[1];
  assign bus.c_o           = driving & vec[0];
  assign bus.busy          = driving;
  assign bus.done          = (state == ST_DONE);
  assign bus.fail          = fail;
  assign bus.err_cnt       = err_cnt;
  assign bus.last_fail_vec = last_fail_vec;

endmodule

// File: tb/tb_gate_vector_sweeper.sv
// Bench for gate_vector_sweeper: two instances (defaults, and HOLD_CYCLES=2
// NUM_VEC=3) looped back through a gate-block model with a per-vector
// error mask; every cycle of each sweep is checked against a timeline
// computed from the vector index and hold length.
module tb_gate_vector_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  gate_vector_sweeper_if bus1 ();
  gate_vector_sweeper_if bus2 ();

  gate_vector_sweeper #(.HOLD_CYCLES(10), .NUM_VEC(8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  gate_vector_sweeper #(.HOLD_CYCLES(2), .NUM_VEC(3)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  // truth table of the gate block, bit v = response for {a,b,c} = v
  logic [7:0] d_tab = 8'hD5;
  logic [7:0] e_tab = 8'h55;
  logic [1:0] mask [8];

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] v1, v2;
  always_comb begin
    v1 = {bus1.a_o, bus1.b_o, bus1.c_o};
    v2 = {bus2.a_o, bus2.b_o, bus2.c_o};
    bus1.d_i = d_tab[v1] ^ mask[v1][1];
    bus1.e_i = e_tab[v1] ^ mask[v1][0];
    bus2.d_i = d_tab[v2] ^ mask[v2][1];
    bus2.e_i = e_tab[v2] ^ mask[v2][0];
  end

  logic [2:0]  o_abc;
  logic        o_busy, o_done, o_fail;
  logic [3:0]  o_err;
  logic [2:0]  o_lfv;
  logic [15:0] o_sig;
  always_comb begin
    o_abc  = sel ? {bus2.a_o, bus2.b_o, bus2.c_o} : {bus1.a_o, bus1.b_o, bus1.c_o};
    o_busy = sel ? bus2.busy : bus1.busy;
    o_done = sel ? bus2.done : bus1.done;
    o_fail = sel ? bus2.fail : bus1.fail;
    o_err  = sel ? bus2.err_cnt : bus1.err_cnt;
    o_lfv  = sel ? bus2.last_fail_vec : bus1.last_fail_vec;
`ifdef SWEEP_SIGNATURE_EN
    o_sig  = sel ? bus2.sig_o : bus1.sig_o;
`else
    o_sig  = 16'h0;
`endif
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic s);
    if (sel) bus2.start = s;
    else     bus1.start = s;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_abc"},  16'(o_abc),  16'h0);
    chk({tag, "_busy"}, 16'(o_busy), 16'h0);
    chk({tag, "_done"}, 16'(o_done), 16'h0);
    chk({tag, "_fail"}, 16'(o_fail), 16'h0);
    chk({tag, "_err"},  16'(o_err),  16'h0);
    chk({tag, "_lfv"},  16'(o_lfv),  16'h0);
`ifdef SWEEP_SIGNATURE_EN
    chk({tag, "_sig"},  o_sig,       16'h0);
`endif
  endtask

  // Point k is #1 after edge E0+k; E0 is the edge that samples start.
  task automatic run_sweep(input int h, input int n, input bit extra_start, input int abort_at);
    int          total, sampled, e_err, e_lfv;
    logic [2:0]  e_abc;
    logic        e_busy, e_fail;
    logic [15:0] sig_exp;
    total = n * h;
    @(posedge clk); #1; set_start(1'b1);
    @(posedge clk); #1; set_start(1'b0);
    for (int k = 0; k <= total + 1; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (abort_at > 0 && k == abort_at) begin
        chk_idle_zero("abort");
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(posedge clk); #1;
          chk("abort_nodone", 16'(o_done), 16'h0);
          chk("abort_nobusy", 16'(o_busy), 16'h0);
        end
        return;
      end
      e_busy  = (k < total);
      e_abc   = e_busy ? 3'(k / h) : 3'd0;
      sampled = (k / h < n) ? k / h : n;
      e_err   = 0;
      e_lfv   = 0;
      for (int v = 0; v < sampled; v++) begin
        if (mask[v] != 2'b00) begin
          e_err++;
          e_lfv = v;
        end
      end
      if (e_err > 15) e_err = 15;
      e_fail = (k > 0 && k % h == 0 && k <= total) ? (mask[k / h - 1] != 2'b00) : 1'b0;
      chk($sformatf("abc@%0d", k),  16'(o_abc),  16'(e_abc));
      chk($sformatf("busy@%0d", k), 16'(o_busy), 16'(e_busy));
      chk($sformatf("done@%0d", k), 16'(o_done), 16'(k == total));
      chk($sformatf("fail@%0d", k), 16'(o_fail), 16'(e_fail));
      chk($sformatf("err@%0d", k),  16'(o_err),  16'(e_err));
      chk($sformatf("lfv@%0d", k),  16'(o_lfv),  16'(e_lfv));
      if (extra_start) set_start(k == 29 || k == total);
      if (abort_at > 0 && k == abort_at - 1) rst = 1'b1;
    end
    sig_exp = 16'h0;
    for (int v = 0; v < n; v++)
      sig_exp = {sig_exp[13:0], d_tab[v] ^ mask[v][1], e_tab[v] ^ mask[v][0]};
`ifdef SWEEP_SIGNATURE_EN
    chk("sig_end", o_sig, sig_exp);
`endif
  endtask

  task automatic set_mask_all(input logic [1:0] m);
    for (int v = 0; v < 8; v++) mask[v] = m;
  endtask

  initial begin
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    set_mask_all(2'b00);

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    rst = 1'b0;

    // correct gate block, defaults
    run_sweep(10, 8, 1'b0, 0);
    chk("clean_err", 16'(o_err), 16'd0);
`ifdef SWEEP_SIGNATURE_EN
    chk("clean_sig", o_sig, 16'hCCCE);
`endif

    // d stuck at 0
    for (int v = 0; v < 8; v++) mask[v] = {d_tab[v], 1'b0};
    run_sweep(10, 8, 1'b0, 0);
    chk("dstuck_err", 16'(o_err), 16'd5);
    chk("dstuck_lfv", 16'(o_lfv), 16'd7);

    // e inverted
    set_mask_all(2'b01);
    run_sweep(10, 8, 1'b0, 0);
    chk("einv_err", 16'(o_err), 16'd8);
    chk("einv_lfv", 16'(o_lfv), 16'd7);

    // start re-asserted mid-sweep and during done: ignored
    set_mask_all(2'b00);
    run_sweep(10, 8, 1'b1, 0);

    // reset mid-sweep, then a clean sweep
    for (int v = 0; v < 8; v++) mask[v] = 2'($urandom_range(0, 3));
    mask[0] = 2'b11;
    run_sweep(10, 8, 1'b0, 25);
    set_mask_all(2'b00);
    run_sweep(10, 8, 1'b0, 0);
    chk("post_abort_err", 16'(o_err), 16'd0);

    // randomized error masks
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < 8; v++) mask[v] = 2'($urandom_range(0, 3));
      run_sweep(10, 8, 1'b0, 0);
    end

    // short instance: HOLD_CYCLES=2, NUM_VEC=3
    sel = 1'b1;
    set_mask_all(2'b00);
    run_sweep(2, 3, 1'b0, 0);
    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v < 8; v++) mask[v] = 2'($urandom_range(0, 3));
      run_sweep(2, 3, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
